// File: rtl/sram_bridge.sv
// sram_bridge: splits bus word accesses into SRAM beats with registered, glitch-free active-low strobes
module sram_bridge #(
    parameter int BUS_DW  = 32,
    parameter int SRAM_DW = 16,
    parameter int SRAM_AW = 18,
    parameter int BUS_AW  = 20,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_bus_req,
    input  logic                 i_bus_write,
    input  logic [BUS_AW-1:0]    i_bus_addr,
    input  logic [BUS_DW-1:0]    i_bus_wdata,
    input  logic [BUS_DW/8-1:0]  i_bus_byteen,
    output logic                 o_bus_ack,
    output logic [BUS_DW-1:0]    o_bus_rdata,
    output logic                 o_bus_busy,
    output logic [SRAM_AW-1:0]   o_sram_addr,
    output logic [SRAM_DW-1:0]   o_sram_dq_out,
    output logic                 o_sram_dq_oe,
    input  logic [SRAM_DW-1:0]   i_sram_dq_in,
    output logic                 o_sram_ce_n,
    output logic                 o_sram_oe_n,
    output logic                 o_sram_we_n,
    output logic [SRAM_DW/8-1:0] o_sram_be_n
);
    localparam int N    = BUS_DW / SRAM_DW;
    localparam int KW   = $clog2(N);
    localparam int BW   = (KW > 0) ? KW : 1;
    localparam int NL   = SRAM_DW / 8;
    localparam int SB   = $clog2(NL);
    localparam int MAXW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CW   = $clog2(MAXW + 1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_ACK} state_t;

    state_t               r_state, w_state_nxt;
    logic [BW-1:0]        r_k, w_k_nxt, w_idx;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [SRAM_AW-1:0]   r_waddr, w_src_a, w_beat_addr;
    logic [BUS_DW-1:0]    r_wdata, w_src_wd, r_rbuf, w_rbuf_nxt;
    logic [BUS_DW/8-1:0]  r_be, w_src_be;
    logic                 w_idle, w_found, w_rd_last, w_rd_nxt, w_wr_nxt;
    int                   w_start;
    logic                 w_unused;

    // Low address bits select bytes inside a bus word and are not needed by the SRAM side
    assign w_unused = ^i_bus_addr;

    // Next-state logic: beat sequencing, wait counting and next enabled write beat search
    always_comb begin
        w_idle      = r_state == S_IDLE;
        w_src_a     = w_idle ? i_bus_addr[SRAM_AW+SB-1:SB] : r_waddr;
        w_src_wd    = w_idle ? i_bus_wdata : r_wdata;
        w_src_be    = w_idle ? i_bus_byteen : r_be;
        w_start     = w_idle ? 0 : int'(r_k) + 1;
        w_found     = 1'b0;
        w_idx       = '0;
        for (int j = N - 1; j >= 0; j--)
            if (j >= w_start && |w_src_be[j*NL +: NL]) begin
                w_found = 1'b1;
                w_idx   = BW'(j);
            end
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_cnt_nxt   = r_cnt;
        w_rd_last   = 1'b0;
        case (r_state)
            S_IDLE:
                if (i_bus_req) begin
                    w_cnt_nxt   = '0;
                    w_k_nxt     = i_bus_write ? w_idx : '0;
                    w_state_nxt = !i_bus_write ? S_RD : w_found ? S_WR_SETUP : S_ACK;
                end
            S_RD:
                if (r_cnt == CW'(RD_WAIT - 1)) begin
                    w_rd_last   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_k == BW'(N - 1)) ? S_ACK : S_RD;
                    w_k_nxt     = (r_k == BW'(N - 1)) ? r_k : r_k + 1'b1;
                end else
                    w_cnt_nxt = r_cnt + 1'b1;
            S_WR_SETUP: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WR_PULSE;
            end
            S_WR_PULSE:
                if (r_cnt == CW'(WR_WAIT - 1)) w_state_nxt = S_WR_HOLD;
                else w_cnt_nxt = r_cnt + 1'b1;
            S_WR_HOLD: begin
                w_state_nxt = w_found ? S_WR_SETUP : S_ACK;
                w_k_nxt     = w_found ? w_idx : r_k;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_rd_nxt    = w_state_nxt == S_RD;
        w_wr_nxt    = w_state_nxt == S_WR_SETUP || w_state_nxt == S_WR_PULSE || w_state_nxt == S_WR_HOLD;
        w_beat_addr = (w_src_a & ~SRAM_AW'(N - 1)) | SRAM_AW'(w_k_nxt);
        w_rbuf_nxt  = r_rbuf;
        if (w_rd_last) w_rbuf_nxt[r_k*SRAM_DW +: SRAM_DW] = i_sram_dq_in;
    end

    // FSM state and captured request attributes
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_cnt   <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rbuf  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rbuf  <= w_rbuf_nxt;
            if (w_idle && i_bus_req) begin
                r_waddr <= w_src_a;
                r_wdata <= i_bus_wdata;
                r_be    <= i_bus_byteen;
            end
        end

    // Outputs registered from the next state so strobes never glitch
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            o_sram_ce_n   <= 1'b1;
            o_sram_oe_n   <= 1'b1;
            o_sram_we_n   <= 1'b1;
            o_sram_be_n   <= '1;
            o_sram_dq_oe  <= 1'b0;
            o_sram_addr   <= '0;
            o_sram_dq_out <= '0;
            o_bus_ack     <= 1'b0;
            o_bus_busy    <= 1'b0;
            o_bus_rdata   <= '0;
        end else begin
            o_sram_ce_n  <= !(w_rd_nxt || w_wr_nxt);
            o_sram_oe_n  <= !w_rd_nxt;
            o_sram_we_n  <= w_state_nxt != S_WR_PULSE;
            o_sram_dq_oe <= w_wr_nxt;
            o_sram_be_n  <= w_rd_nxt ? '0 : w_wr_nxt ? ~w_src_be[w_k_nxt*NL +: NL] : '1;
            o_bus_ack    <= w_state_nxt == S_ACK;
            o_bus_busy   <= w_state_nxt != S_IDLE;
            if (w_rd_nxt || w_state_nxt == S_WR_SETUP) o_sram_addr <= w_beat_addr;
            if (w_state_nxt == S_WR_SETUP) o_sram_dq_out <= w_src_wd[w_k_nxt*SRAM_DW +: SRAM_DW];
            if (w_rd_last && r_k == BW'(N - 1)) o_bus_rdata <= w_rbuf_nxt;
        end
endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: random and directed bus traffic against a byte-array reference memory
module tb_sram_bridge;
    localparam int N   = 2;
    localparam int RDW = 2;
    localparam int WRW = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        req = 1'b0, write = 1'b0;
    logic [19:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  byteen = '0;
    logic        ack, busy;
    logic [31:0] rdata;
    logic [17:0] s_addr;
    logic [15:0] s_dq_out, s_dq_in;
    logic        dq_oe, ce_n, oe_n, we_n;
    logic [1:0]  be_n;

    logic        b_req = 1'b0, b_write = 1'b0;
    logic [19:0] b_addr = '0;
    logic [31:0] b_wdata = '0;
    logic [3:0]  b_be = '0;
    logic        b_ack, b_busy;
    logic [31:0] b_rdata;
    logic [17:0] b_saddr;
    logic [31:0] b_dq_out, b_dq_in;
    logic        b_dq_oe, b_ce_n, b_oe_n, b_we_n;
    logic [3:0]  b_be_n;

    sram_bridge u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_bus_req(req), .i_bus_write(write),
        .i_bus_addr(addr), .i_bus_wdata(wdata), .i_bus_byteen(byteen),
        .o_bus_ack(ack), .o_bus_rdata(rdata), .o_bus_busy(busy),
        .o_sram_addr(s_addr), .o_sram_dq_out(s_dq_out), .o_sram_dq_oe(dq_oe),
        .i_sram_dq_in(s_dq_in), .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n),
        .o_sram_we_n(we_n), .o_sram_be_n(be_n)
    );

    sram_bridge #(.SRAM_DW(32), .RD_WAIT(1), .WR_WAIT(3)) u_dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_bus_req(b_req), .i_bus_write(b_write),
        .i_bus_addr(b_addr), .i_bus_wdata(b_wdata), .i_bus_byteen(b_be),
        .o_bus_ack(b_ack), .o_bus_rdata(b_rdata), .o_bus_busy(b_busy),
        .o_sram_addr(b_saddr), .o_sram_dq_out(b_dq_out), .o_sram_dq_oe(b_dq_oe),
        .i_sram_dq_in(b_dq_in), .o_sram_ce_n(b_ce_n), .o_sram_oe_n(b_oe_n),
        .o_sram_we_n(b_we_n), .o_sram_be_n(b_be_n)
    );

    // Behavioural asynchronous SRAMs with byte lanes
    logic [7:0]  smem  [0:1023] = '{default: 8'h00};
    logic [31:0] smem2 [0:255]  = '{default: 32'h0};
    logic [7:0]  rmem  [0:1023] = '{default: 8'h00};
    logic [7:0]  rmem2 [0:1023] = '{default: 8'h00};

    always @(posedge clk) begin
        if (!ce_n && !we_n)
            for (int l = 0; l < 2; l++)
                if (!be_n[l]) smem[(int'(s_addr) * 2 + l) & 1023] <= s_dq_out[l*8 +: 8];
        if (!b_ce_n && !b_we_n)
            for (int l = 0; l < 4; l++)
                if (!b_be_n[l]) smem2[b_saddr[7:0]][l*8 +: 8] <= b_dq_out[l*8 +: 8];
    end

    always_comb begin
        s_dq_in = 16'h0;
        b_dq_in = 32'h0;
        if (!ce_n && !oe_n) s_dq_in = {smem[(int'(s_addr) * 2 + 1) & 1023], smem[(int'(s_addr) * 2) & 1023]};
        if (!b_ce_n && !b_oe_n) b_dq_in = smem2[b_saddr[7:0]];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Write-pulse protocol monitor: address/data/lanes stable from the cycle before we_n falls to the cycle after it rises
    logic        p_we_n = 1'b1, p_oe = 1'b0, p_ce_n = 1'b1;
    logic [17:0] p_addr = '0;
    logic [15:0] p_dq = '0;
    logic [1:0]  p_be = '1;
    int          viol = 0;
    bit          mon_en = 1'b1;
    logic [35:0] pulses[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if ((!we_n || !p_we_n) && !(dq_oe && p_oe && !ce_n && !p_ce_n &&
                s_addr == p_addr && s_dq_out == p_dq && be_n == p_be)) viol++;
            if (!oe_n && dq_oe) viol++;
            if (!we_n && p_we_n) pulses.push_back({s_addr, s_dq_out, be_n});
        end
        p_we_n = we_n; p_oe = dq_oe; p_ce_n = ce_n;
        p_addr = s_addr; p_dq = s_dq_out; p_be = be_n;
    end

    task automatic op(input logic wr, input logic [19:0] a, input logic [31:0] d, input logic [3:0] be);
        int base, m, ack_c, we_c, oe_c, ce_c;
        logic [31:0] exp_rd, got_rd;
        logic busy_at_ack;
        logic [1:0] post;
        base = int'(a[9:0]) & ~3;
        m = int'(|be[1:0]) + int'(|be[3:2]);
        for (int i = 0; i < 4; i++) exp_rd[i*8 +: 8] = rmem[base + i];
        if (wr) for (int i = 0; i < 4; i++) if (be[i]) rmem[base + i] = d[i*8 +: 8];
        @(posedge clk); #1;
        req = 1'b1; write = wr; addr = a; wdata = d; byteen = be;
        ack_c = -1; we_c = 0; oe_c = 0; ce_c = 0; got_rd = '0; busy_at_ack = 1'b0;
        for (int c = 0; c < 100 && ack_c < 0; c++) begin
            @(negedge clk);
            if (!we_n) we_c++;
            if (!oe_n) oe_c++;
            if (!ce_n) ce_c++;
            if (ack) begin
                ack_c = c; got_rd = rdata; busy_at_ack = busy;
            end
        end
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        post = {ack, busy};
        chk("ack_cycle", 64'(ack_c), wr ? 64'(m * (WRW + 2) + 1) : 64'(N * RDW + 1));
        chk("we_low_cycles", 64'(we_c), wr ? 64'(m * WRW) : 64'(0));
        chk("oe_low_cycles", 64'(oe_c), wr ? 64'(0) : 64'(N * RDW));
        chk("ce_low_cycles", 64'(ce_c), wr ? 64'(m * (WRW + 2)) : 64'(N * RDW));
        chk("busy_at_ack", 64'(busy_at_ack), 64'(1));
        chk("idle_after_ack", 64'(post), 64'(0));
        if (!wr) chk("rdata", 64'(got_rd), 64'(exp_rd));
    endtask

    task automatic op2(input logic wr, input logic [19:0] a, input logic [31:0] d, input logic [3:0] be);
        int base, m, ack_c, we_c;
        logic [31:0] exp_rd, got_rd;
        base = int'(a[9:0]) & ~3;
        m = int'(|be);
        for (int i = 0; i < 4; i++) exp_rd[i*8 +: 8] = rmem2[base + i];
        if (wr) for (int i = 0; i < 4; i++) if (be[i]) rmem2[base + i] = d[i*8 +: 8];
        @(posedge clk); #1;
        b_req = 1'b1; b_write = wr; b_addr = a; b_wdata = d; b_be = be;
        ack_c = -1; we_c = 0; got_rd = '0;
        for (int c = 0; c < 100 && ack_c < 0; c++) begin
            @(negedge clk);
            if (!b_we_n) we_c++;
            if (b_ack) begin
                ack_c = c; got_rd = b_rdata;
            end
        end
        @(posedge clk); #1;
        b_req = 1'b0;
        chk("dw32_ack_cycle", 64'(ack_c), wr ? 64'(m * 5 + 1) : 64'(2));
        chk("dw32_we_cycles", 64'(we_c), wr ? 64'(m * 3) : 64'(0));
        if (!wr) chk("dw32_rdata", 64'(got_rd), 64'(exp_rd));
    endtask

    initial begin
        bit found, ack_seen;
        #12;
        chk("rst_strobes", 64'({ce_n, oe_n, we_n, be_n, dq_oe}), 64'(6'b111110));
        chk("rst_addr", 64'(s_addr), 64'(0));
        chk("rst_dq_out", 64'(s_dq_out), 64'(0));
        chk("rst_ack_busy", 64'({ack, busy}), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        pulses.delete();
        op(1'b1, 20'h100, 32'hDEADBEEF, 4'hF);
        chk("full_pulse_count", 64'(pulses.size()), 64'(2));
        while (pulses.size() < 2) pulses.push_back('0);
        chk("full_beat0", 64'(pulses[0]), 64'({18'h080, 16'hBEEF, 2'b00}));
        chk("full_beat1", 64'(pulses[1]), 64'({18'h081, 16'hDEAD, 2'b00}));

        pulses.delete();
        op(1'b1, 20'h100, 32'h00AB0000, 4'h4);
        chk("part_pulse_count", 64'(pulses.size()), 64'(1));
        while (pulses.size() < 1) pulses.push_back('0);
        chk("part_beat", 64'(pulses[0]), 64'({18'h081, 16'h00AB, 2'b10}));
        chk("part_sram_bytes", 64'({smem[259], smem[258], smem[257], smem[256]}), 64'(32'hDEABBEEF));

        op(1'b1, 20'h104, 32'h12345678, 4'h0);
        op(1'b0, 20'h100, 32'h0, 4'h0);
        chk("rd_0x100", 64'(rdata), 64'(32'hDEABBEEF));

        for (int t = 0; t < 40; t++)
            op(1'($urandom_range(0, 1)), 20'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)),
               $urandom, 4'($urandom_range(0, 15)));
        chk("protocol_violations", 64'(viol), 64'(0));

        mon_en = 1'b0;
        @(posedge clk); #1;
        req = 1'b1; write = 1'b1; addr = 20'h200; wdata = 32'h12345678; byteen = 4'hF;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            found = !we_n;
        end
        chk("reach_we_pulse", 64'(found), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_we_ce", 64'({we_n, ce_n}), 64'(2'b11));
        chk("rst_async_busy_oe", 64'({busy, dq_oe}), 64'(0));
        req = 1'b0;
        ack_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            ack_seen |= ack;
        end
        rst_n = 1'b1;
        chk("no_ack_after_rst", 64'(ack_seen), 64'(0));
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        op(1'b0, 20'h100, 32'h0, 4'h0);
        op(1'b0, 20'h200, 32'h0, 4'h0);

        op2(1'b1, 20'h040, 32'hCAFEF00D, 4'hF);
        op2(1'b0, 20'h040, 32'h0, 4'h0);
        chk("dw32_rd_const", 64'(b_rdata), 64'(32'hCAFEF00D));
        op2(1'b1, 20'h042, 32'h11223344, 4'h5);
        op2(1'b0, 20'h041, 32'h0, 4'h0);
        chk("dw32_part_const", 64'(b_rdata), 64'(32'hCA22F044));
        op2(1'b1, 20'h044, 32'h55555555, 4'h0);
        for (int t = 0; t < 12; t++)
            op2(1'($urandom_range(0, 1)), 20'($urandom_range(0, 7) * 4),
                $urandom, 4'($urandom_range(0, 15)));
        chk("protocol_violations_end", 64'(viol), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_bridge.md
# sram_bridge

Synthesizable bridge between the SoC's word-wide request/acknowledge data bus and an external asynchronous SRAM of narrower, parametrised width. It splits each bus access into SRAM beats and generates registered, glitch-free active-low strobes with programmable read wait and write pulse lengths. It places byte lanes little-endian, so the bus word at byte address A occupies SRAM bytes A..A+3. It sits between the data-bus interconnect and the board-level SRAM pins, and replaces the fixed 16-bit behavioural SRAM hookup with a parametrised controller.

## Interface
- BUS_DW, 32: bus data width; integer multiple of SRAM_DW; ratio N = BUS_DW/SRAM_DW is a power of 2, N ≥ 1.
- SRAM_DW, 16: SRAM data width; multiple of 8.
- SRAM_AW, 18: SRAM word address width.
- BUS_AW, 20: bus byte address width; ≥ SRAM_AW + log2(SRAM_DW/8).
- RD_WAIT, 2: cycles per read beat, ≥ 1.
- WR_WAIT, 1: cycles we_n is held low per write beat, ≥ 1.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- bus_req  in  1  request; held with attributes stable until bus_ack.
- bus_write  in  1  1 = write, 0 = read.
- bus_addr  in  BUS_AW  byte address; low log2(BUS_DW/8) bits ignored.
- bus_wdata  in  BUS_DW  write data.
- bus_byteen  in  BUS_DW/8  write byte enables; ignored on reads.
- bus_ack  out  1  one-cycle completion pulse.
- bus_rdata  out  BUS_DW  read data; valid in the bus_ack cycle of a read, held until the next read completes.
- bus_busy  out  1  high from the accept edge through the ack cycle.
- sram_addr  out  SRAM_AW  SRAM word address.
- sram_dq_out  out  SRAM_DW  write data to the pad.
- sram_dq_oe  out  1  pad output enable; the top level builds the tri-state.
- sram_dq_in  in  SRAM_DW  data from the pad.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes.
- sram_be_n  out  SRAM_DW/8  active-low byte lane enables; bit 0 = lowest byte (lb).

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
- IDLE: bus_req=1 captures address, data and byte enables; beat index k=0.
  - Read: go to RD.
  - Write: skip to the first beat with nonzero enables and go to WR_SETUP; if all enables are 0, go straight to ACK.
- Beat address: sram_addr = {bus_addr[SRAM_AW+log2(SRAM_DW/8)-1 : log2(BUS_DW/8)], k}. With N=1 the k field is absent.
- Beat k carries bus bits [(k+1)*SRAM_DW-1 : k*SRAM_DW].
- RD: ce_n=0, oe_n=0, we_n=1, be_n all 0, dq_oe=0.
  - Hold for RD_WAIT cycles; sample sram_dq_in into lane k on the edge ending the last cycle.
  - Then go to the next beat (all beats are read), or to ACK after beat N-1.
- WR_SETUP, 1 cycle: ce_n=0, we_n=1, oe_n=1, dq_oe=1, be_n = ~byteen lane slice.
- WR_PULSE, WR_WAIT cycles: as WR_SETUP but we_n=0.
- WR_HOLD, 1 cycle: we_n=1; address, data and be_n unchanged.
- After WR_HOLD: go to the next beat with nonzero enables, else to ACK. Beats with zero enables are skipped entirely.
- ACK, 1 cycle: bus_ack=1, all strobes inactive, then IDLE. If bus_req is still high in IDLE it is a new request, so the master drops req in the cycle after ack unless it is issuing another.
- Wait-cycle counter width is clog2(max(RD_WAIT, WR_WAIT)+1); beat counter width is log2(N), minimum 1.

## Timing
- All outputs are registered.
- Reset values: ce_n=1, oe_n=1, we_n=1, be_n all 1, dq_oe=0, sram_addr=0, sram_dq_out=0, bus_ack=0, bus_busy=0, bus_rdata=0.
- Reset assertion forces these values asynchronously, including mid-transaction. The transaction is dropped with no ack and the FSM returns to IDLE.
- Cycle 0 is the IDLE cycle in which bus_req is sampled high.
- Read: beats occupy cycles 1..N*RD_WAIT; bus_ack in cycle N*RD_WAIT+1.
- Write with m enabled beats: bus_ack in cycle m*(WR_WAIT+2)+1. With m=0, bus_ack in cycle 1.
- Address, data and be_n are stable for the whole time we_n is low. Write data is driven 1 cycle before and 1 cycle after the pulse.
- ce_n stays low across consecutive beats; it rises in ACK.
- Minimum spacing between requests: ack, then IDLE, then accept.

## Test plan
Defaults apply unless noted; a behavioural SRAM model with byte lanes is attached.

- Full write, addr 0x100, data 0xDEADBEEF, be 0xF -> sram_addr 0x080 data 0xBEEF be_n 2'b00, then 0x081 data 0xDEAD; we_n low exactly 1 cycle per beat; ack in cycle 7.
- Partial write, addr 0x100, be 0x4, data 0x00AB0000 -> single beat at 0x081, be_n 2'b10, only SRAM byte 0x102 becomes 0xAB; ack in cycle 4.
- Write with be 0x0 -> ce_n never falls; ack in cycle 1.
- Read of 0x100 after the first two writes -> bus_rdata 0xDEABBEEF; oe_n low cycles 1-4; ack in cycle 5.
- Reset pulled low during WR_PULSE -> we_n and ce_n go high immediately, no ack; a read issued after release completes normally.
- Parameters SRAM_DW=32, RD_WAIT=1, WR_WAIT=3 -> a single beat per access; read ack in cycle 2, full write ack in cycle 6.
